// File: rtl/cam_frame_rx_if.sv
// Camera byte bus plus the pixel valid/ready stream of the frame receiver.
// The master side drives the camera pins and consumes pixels. The slave side is the receiver.
interface cam_frame_rx_if;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic [15:0] pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_valid;
  logic        pix_ready;

  modport master (
    output cam_vsync, cam_href, cam_data, pix_ready,
    input  pix_data, pix_sof, pix_eol, pix_valid
  );

  modport slave (
    input  cam_vsync, cam_href, cam_data, pix_ready,
    output pix_data, pix_sof, pix_eol, pix_valid
  );
endinterface

// File: rtl/cam_frame_rx.sv
// Rebuilds RGB565 pixels from the 8-bit camera bus and checks frame geometry.
// Pixels leave through a small first-word-fall-through FIFO with sof/eol tags.
module cam_frame_rx #(
  parameter int HRES       = 640,
  parameter int VRES       = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          clr_err_i,
  cam_frame_rx_if.slave bus_if,
  output logic          frame_done_o,
  output logic [15:0]   frame_cnt_o,
  output logic          err_geom_o,
  output logic          err_ovf_o
);
  localparam int NPIX   = HRES * VRES;
  localparam int COL_W  = (HRES > 1) ? $clog2(HRES) : 1;
  localparam int LINE_W = $clog2(VRES + 1);
  localparam int PCNT_W = $clog2(NPIX + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_VSYNC, S_ACTIVE} state_t;

  state_t              state_q, state_d;
  logic                phase_q, phase_d;
  logic [7:0]          hi_q;
  logic [COL_W-1:0]    col_q, col_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic                frame_done_q;
  logic [15:0]         frame_cnt_q;
  logic                err_geom_q, err_geom_d;
  logic                err_ovf_q, err_ovf_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [17:0]         mem [FIFO_DEPTH];

  logic frm_clr, byte_en, frm_end, half_drop;
  logic pix_fire, in_frame, push_req, push, pop, full, geom_err, ovf_err;
  logic [17:0] wdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (bus_if.cam_vsync)  state_d = S_VSYNC;
        S_VSYNC:  if (!bus_if.cam_vsync) state_d = S_ACTIVE;
        S_ACTIVE: if (bus_if.cam_vsync)  state_d = S_VSYNC;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // A dropped enable freezes everything: no byte capture, no frame-end check.
  always_comb begin
    frm_clr   = 1'b0;
    byte_en   = 1'b0;
    frm_end   = 1'b0;
    half_drop = 1'b0;
    if (en_i) begin
      case (state_q)
        S_VSYNC: frm_clr = 1'b1;
        S_ACTIVE: begin
          if (bus_if.cam_vsync)     frm_end   = 1'b1;
          else if (bus_if.cam_href) byte_en   = 1'b1;
          else if (phase_q)         half_drop = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pix_fire = byte_en && phase_q;
  assign in_frame = (pcnt_q != PCNT_W'(NPIX));
  assign push_req = pix_fire && in_frame;
  assign pop      = (cnt_q != '0) && bus_if.pix_ready;
  assign full     = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign push     = push_req && (!full || pop);
  assign ovf_err  = push_req && full && !pop;
  assign geom_err = half_drop || (pix_fire && !in_frame) ||
                    (frm_end && (!in_frame ? 1'b0 : 1'b1)) ||
                    (frm_end && phase_q);
  assign wdata    = {(col_q == '0) && (line_q == '0),
                     col_q == COL_W'(HRES - 1),
                     hi_q, bus_if.cam_data};

  // Overflow-dropped pixels still advance the geometry counters.
  always_comb begin
    phase_d = phase_q;
    col_d   = col_q;
    line_d  = line_q;
    pcnt_d  = pcnt_q;
    if (frm_clr) begin
      phase_d = 1'b0;
      col_d   = '0;
      line_d  = '0;
      pcnt_d  = '0;
    end else if (half_drop) begin
      phase_d = 1'b0;
    end else if (byte_en) begin
      phase_d = ~phase_q;
      if (push_req) begin
        pcnt_d = pcnt_q + PCNT_W'(1);
        if (col_q == COL_W'(HRES - 1)) begin
          col_d  = '0;
          line_d = line_q + LINE_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
    end
  end

  always_comb begin
    err_geom_d = clr_err_i ? 1'b0 : err_geom_q;
    err_ovf_d  = clr_err_i ? 1'b0 : err_ovf_q;
    if (geom_err) err_geom_d = 1'b1;
    if (ovf_err)  err_ovf_d  = 1'b1;
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q      <= 1'b0;
      col_q        <= '0;
      line_q       <= '0;
      pcnt_q       <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_geom_q   <= 1'b0;
      err_ovf_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      phase_q      <= phase_d;
      col_q        <= col_d;
      line_q       <= line_d;
      pcnt_q       <= pcnt_d;
      frame_done_q <= frm_end;
      frame_cnt_q  <= frame_cnt_q + 16'(frm_end);
      err_geom_q   <= err_geom_d;
      err_ovf_q    <= err_ovf_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q        <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (byte_en && !phase_q) hi_q <= bus_if.cam_data;
    if (push) mem[wr_ptr_q] <= wdata;
  end

  // Head is masked while empty so the stream outputs read zero out of reset.
  assign bus_if.pix_valid = (cnt_q != '0);
  assign {bus_if.pix_sof, bus_if.pix_eol, bus_if.pix_data} =
    bus_if.pix_valid ? mem[rd_ptr_q] : 18'd0;

  assign frame_done_o = frame_done_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign err_geom_o   = err_geom_q;
  assign err_ovf_o    = err_ovf_q;
endmodule

// File: doc/cam_frame_rx.md
# cam_frame_rx

Pixel-stream receiver that consumes the 8-bit parallel camera bus (vsync, href, data), as produced by the camera VIP or a real sensor, and rebuilds RGB565 pixels. It sits directly downstream of the camera pins. It emits 16-bit pixels through a small first-word-fall-through FIFO with a valid/ready handshake, tags start-of-frame and end-of-line, and checks frame geometry. Frame and error status is exposed for the bench and for the uDMA-side consumer.

## Interface
- HRES, 640, pixels per line
- VRES, 480, lines per frame
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)
- clk_i  in  1  camera pixel clock; all sampling on posedge
- rst_i  in  1  asynchronous, active-high reset
- en_i  in  1  receiver enable, synchronous
- clr_err_i  in  1  synchronous clear of the sticky error flags
- cam_vsync_i  in  1  frame sync; high = vertical blanking
- cam_href_i  in  1  byte qualifier; high = data byte valid
- cam_data_i  in  8  camera data byte
- pix_data_o  out  16  RGB565 pixel {first byte, second byte}
- pix_sof_o  out  1  pixel is (col 0, line 0) of its frame
- pix_eol_o  out  1  pixel is col HRES-1
- pix_valid_o  out  1  FIFO head valid
- pix_ready_i  in  1  consumer accepts head when valid&ready
- frame_done_o  out  1  one-cycle pulse at frame end
- frame_cnt_o  out  16  completed frames, wraps at 2^16
- err_geom_o  out  1  sticky geometry error
- err_ovf_o  out  1  sticky FIFO overflow (pixel dropped)

## Operation
- States: IDLE, VSYNC, ACTIVE.
- IDLE: wait for en_i=1 and cam_vsync_i=1, then go to VSYNC. Data is ignored.
- VSYNC: cam_vsync_i=0 → ACTIVE. Clear the byte phase, column counter, line counter, and per-frame pixel counter.
- ACTIVE, each cycle with cam_href_i=1:
  - byte phase 0: latch cam_data_i as the high byte.
  - byte phase 1: form pixel {hi, cam_data_i} and push it with sof = (col==0 && line==0) and eol = (col==HRES-1).
  - Column wraps HRES-1→0 and the line then increments. Line boundaries come only from the column counter; href may stay high across lines or drop between them.
- href falling while byte phase = 1 (odd byte count): drop the half pixel, clear the phase, set err_geom_o.
- Pixels beyond HRES*VRES in a frame: not pushed; set err_geom_o.
- ACTIVE with cam_vsync_i=1 ends the frame:
  - pulse frame_done_o
  - increment frame_cnt_o
  - if pixel count != HRES*VRES or the phase is odd, set err_geom_o
  - go to VSYNC
- FIFO push when full with no simultaneous pop: drop the pixel and set err_ovf_o. Push and pop in the same cycle when full: both succeed.
- en_i=0: go to IDLE next cycle, abandoning the current frame. No frame_done_o, no frame_cnt_o increment, no geometry check. The FIFO keeps its contents and keeps draining. After re-enable, capture resumes only at the next vsync rise.
- clr_err_i clears both errors. If clr_err_i and a new error occur in the same cycle, the error wins.

## Timing
- Reset: state IDLE, FIFO empty. All outputs are 0: pix_data_o, pix_sof_o, pix_eol_o, pix_valid_o, frame_done_o, frame_cnt_o, err_geom_o, err_ovf_o.
- Inputs are sampled at posedge clk_i. Benches drive them off-edge or on negedge.
- Latency: second byte sampled at edge N → pix_valid_o=1 after edge N, when the FIFO was empty.
- Handshake: the head may change only after an edge where valid&ready=1. Data and flags are stable while valid&~ready.
- frame_done_o and the error flags update after the edge where vsync=1 is first sampled in ACTIVE.
- Sustained throughput: one pixel per two clocks; FIFO_DEPTH absorbs up to FIFO_DEPTH*2 cycles of ready=0.

## Test plan
- Nominal, HRES=4 VRES=2, href continuous for 16 bytes 0x00..0x0F, ready=1:
  - 8 pixels 0x0001, 0x0203, …, 0x0E0F
  - sof only on 0x0001; eol on 0x0607 and 0x0E0F
  - one frame_done_o pulse; frame_cnt_o=1; no errors
- Same frame with href dropped for 3 cycles between lines, sent twice: identical output for both frames; frame_cnt_o=2.
- ready=0 for the whole frame with FIFO_DEPTH=4:
  - first 4 pixels are held and 4 are dropped; err_ovf_o=1
  - releasing ready drains 0x0001..0x0607 in order
- Odd href (3 bytes, then href low) inside the frame: err_geom_o=1. The next valid byte pair forms the next pixel; clr_err_i clears the flag.
- Short frame (6 pixels, then vsync): frame_done_o pulses; err_geom_o=1; frame_cnt_o increments.
- en_i low after 3 pixels, high again before the next vsync, then a full frame: the first frame yields 3 pixels and no frame_done_o; the next frame is captured correctly. rst_i mid-frame: all outputs 0 immediately.
